clk_div_prog: RTL and testbench
===============================

Name: clk_div_prog

Overview:
- Multi-channel programmable clock divider. It generalises the fixed /2../16 divider to NUM_CH independent channels.
- Each channel divides by any integer D in 2..2^CNT_W-1, set at run time. Odd and even divisors are both supported.
- Each channel drives a registered divided-clock output and a one-cycle tick (clock-enable) pulse.
- Divisor changes and channel stops are glitch-free: they take effect only at a period boundary.
- Sits beside the system clock generator and feeds slow enables to peripherals (UART baud, PWM, timers).

Parameters:
- NUM_CH, 4, number of independent divider channels (1..16).
- CNT_W, 8, counter and divisor width in bits.
- DEF_DIV, 2, divisor loaded into every channel at reset (must be >= 2).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-low (rst==0 resets).
- en  in  1  global enable; ANDed with each ch_en bit.
- ch_en  in  NUM_CH  per-channel run request.
- cfg_wr  in  1  one-cycle divisor write strobe.
- cfg_ch  in  clog2(NUM_CH) (min 1)  channel index for cfg_wr.
- cfg_div  in  CNT_W  new divisor value.
- clk_out  out  NUM_CH  divided clock per channel (registered).
- tick  out  NUM_CH  one-cycle pulse at the start of each output period.
- cfg_pend  out  NUM_CH  divisor write accepted but not yet applied.
- running  out  NUM_CH  channel is in RUN or STOPPING.

Behaviour:
- Reset (rst low, async): for every channel state=IDLE, cnt=0, div_cur=DEF_DIV, div_pend=DEF_DIV, clk_out=0, tick=0, cfg_pend=0, running=0.
- Per-channel FSM, go_i = en & ch_en[i]:
  - IDLE: cnt=0, clk_out=0, tick=0. If go_i, next edge -> RUN with cnt=0, clk_out=1, tick=1.
  - RUN: each edge cnt <= (cnt==div_cur-1) ? 0 : cnt+1. That wrap edge is the period boundary. If go_i is low at a boundary edge -> STOPPING.
  - STOPPING: counting continues until the next boundary edge, then -> IDLE. If go_i is high again before that edge -> RUN, with no break in the waveform.
  - Net effect: a drop of go_i always completes the current period, then adds one more full period, then stops with clk_out=0.
- Output timing, all registered and reflecting the post-edge cnt:
  - clk_out=1 while cnt < ceil(div_cur/2), else 0. High for ceil(D/2) cycles, low for floor(D/2).
  - tick=1 when cnt==0 and state is RUN or STOPPING.
  - Period is exactly div_cur clk cycles.
- Divisor write (cfg_wr=1):
  - cfg_div < 2 is clamped to 2.
  - cfg_ch >= NUM_CH: write ignored, no flags change.
  - Target channel IDLE: div_cur updated at that edge; cfg_pend stays 0.
  - Target channel RUN or STOPPING: div_pend <= value and cfg_pend <= 1. At the next boundary edge div_cur <= div_pend and cfg_pend <= 0. The new divisor governs the period starting at that edge.
  - Write on the same edge as a boundary: the written value bypasses div_pend and governs the period starting at that edge; cfg_pend stays 0.
  - Second write while pending: overwrites div_pend; only the last value is applied.
- Channels are fully independent; simultaneous writes and boundaries on different channels do not interact.
- Reset mid-operation: outputs go to reset values immediately; pending writes are lost.
- Width: cnt and div_cur are CNT_W bits. D = 2^CNT_W-1 is the maximum, and cnt never overflows.

Test Plan:
- Reset then en=1, ch_en=4'b0001, D=2 -> clk_out[0] toggles every cycle, tick[0] every 2 cycles, first tick on first edge after enable; other channels stay 0.
- cfg_wr ch0 D=5 while IDLE, then enable -> clk_out[0] high 3 cycles, low 2, period 5; tick every 5 cycles.
- RUN at D=4, write D=7 mid-period -> cfg_pend[0]=1 until the next wrap. The remainder of the current period keeps length 4; the following periods are 7, with high 4 / low 3.
- cfg_wr on the exact boundary edge with D=3 -> the period starting at that edge is 3 cycles; cfg_pend never asserts.
- ch_en[0] dropped at cnt=1 with D=6 -> current period completes, one more 6-cycle period runs, then IDLE with clk_out=0, running=0. Re-raising ch_en before the final boundary gives a continuous waveform.
- cfg_div=0 -> behaves as D=2. cfg_ch=NUM_CH -> no change. rst asserted mid-period -> all outputs 0 asynchronously, div_cur back to DEF_DIV.

Source files
------------

// File: rtl/clk_div_prog.sv
// clk_div_prog: multi-channel programmable clock divider with glitch-free divisor updates and stops
// Ports:
//   clk      - system clock, all logic on rising edge
//   rst      - asynchronous active-low reset
//   en       - global enable, ANDed with each ch_en bit
//   ch_en    - per-channel run request
//   cfg_wr   - one-cycle divisor write strobe
//   cfg_ch   - channel index for cfg_wr (out-of-range indices match no channel)
//   cfg_div  - new divisor (values below 2 are clamped to 2)
//   clk_out  - registered divided clock per channel
//   tick     - one-cycle pulse at the start of each output period
//   cfg_pend - divisor accepted, waiting for the next period boundary
//   running  - channel is in RUN or STOPPING
module clk_div_prog #(
    parameter int NUM_CH = 4,
    parameter int CNT_W = 8,
    parameter int DEF_DIV = 2,
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              cfg_wr,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] cfg_pend,
    output logic [NUM_CH-1:0] running
);
    typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;

    logic [CNT_W-1:0] wr_div;
    assign wr_div = (cfg_div < CNT_W'(2)) ? CNT_W'(2) : cfg_div;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        state_t           state, state_nx;
        logic [CNT_W-1:0] cnt, cnt_nx, div_cur, div_nx, div_pend, div_pend_nx, half;
        logic             pend, pend_nx, clk_q, clk_nx, tick_q, tick_nx, go, wr, bnd;

        always_comb begin
            go          = en & ch_en[i];
            // an index beyond NUM_CH-1 never equals any i, so such writes are dropped
            wr          = cfg_wr && (32'(cfg_ch) == i);
            bnd         = (state != IDLE) && (cnt == div_cur - 1'b1);
            // go wins in RUN/STOPPING, so re-raising during STOPPING resumes without a break
            state_nx    = (state == IDLE) ? (go ? RUN : IDLE) :
                          go ? RUN : bnd ? ((state == RUN) ? STOPPING : IDLE) : state;
            cnt_nx      = (state == IDLE || bnd) ? '0 : cnt + 1'b1;
            // a write on the boundary edge bypasses div_pend and governs the new period
            div_nx      = (state == IDLE) ? (wr ? wr_div : div_cur) :
                          bnd ? (wr ? wr_div : pend ? div_pend : div_cur) : div_cur;
            div_pend_nx = wr ? wr_div : div_pend;
            pend_nx     = (state == IDLE || bnd) ? 1'b0 : (wr | pend);
            // ceil(D/2) without widening: D=2^CNT_W-1 gives 2^(CNT_W-1)
            half        = (div_nx >> 1) + CNT_W'(div_nx[0]);
            clk_nx      = (state_nx != IDLE) && (cnt_nx < half);
            tick_nx     = (state_nx != IDLE) && (cnt_nx == '0);
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                state    <= IDLE;
                cnt      <= '0;
                div_cur  <= CNT_W'(DEF_DIV);
                div_pend <= CNT_W'(DEF_DIV);
                pend     <= 1'b0;
                clk_q    <= 1'b0;
                tick_q   <= 1'b0;
            end else begin
                state    <= state_nx;
                cnt      <= cnt_nx;
                div_cur  <= div_nx;
                div_pend <= div_pend_nx;
                pend     <= pend_nx;
                clk_q    <= clk_nx;
                tick_q   <= tick_nx;
            end
        end

        assign clk_out[i]  = clk_q;
        assign tick[i]     = tick_q;
        assign cfg_pend[i] = pend;
        assign running[i]  = (state != IDLE);
    end
endmodule

// File: tb/tb_clk_div_prog.sv
// tb_clk_div_prog: directed self-checking bench for clk_div_prog
module tb_clk_div_prog;
    logic       clk = 1'b0, rst = 1'b0, en = 1'b0, cfg_wr = 1'b0, cfg_wr3 = 1'b0;
    logic [3:0] ch_en = '0;
    logic [2:0] ch_en3 = '0;
    logic [1:0] cfg_ch = '0, cfg_ch3 = '0;
    logic [7:0] cfg_div = '0;
    logic [3:0] clk_out, tick, cfg_pend, running;
    logic [2:0] clk_out3, tick3, cfg_pend3, running3;
    int vecs = 0, errs = 0;

    always #5 clk = ~clk;

    clk_div_prog u_dut (
        .clk(clk), .rst(rst), .en(en), .ch_en(ch_en), .cfg_wr(cfg_wr), .cfg_ch(cfg_ch),
        .cfg_div(cfg_div), .clk_out(clk_out), .tick(tick), .cfg_pend(cfg_pend), .running(running)
    );

    // three-channel instance so that cfg_ch == NUM_CH is representable
    clk_div_prog #(.NUM_CH(3)) u_dut3 (
        .clk(clk), .rst(rst), .en(en), .ch_en(ch_en3), .cfg_wr(cfg_wr3), .cfg_ch(cfg_ch3),
        .cfg_div(cfg_div), .clk_out(clk_out3), .tick(tick3), .cfg_pend(cfg_pend3), .running(running3)
    );

    task automatic step;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic write(input logic [1:0] ch, input logic [7:0] d);
        cfg_wr = 1'b1; cfg_ch = ch; cfg_div = d;
        step;
        cfg_wr = 1'b0;
    endtask

    task automatic go_idle;
        bit done = 0;
        ch_en = '0;
        for (int n = 0; n < 600 && !done; n++) begin
            step;
            done = (running == 4'b0);
        end
        vecs++;
        if (!done) begin
            errs++;
            $display("FAIL go_idle: running=%b after 600 cycles, required 0000", running);
        end
    endtask

    task automatic test_reset;
        step; step;
        vecs++;
        if ({clk_out, tick, cfg_pend, running} !== 16'h0) begin
            errs++;
            $display("FAIL reset_hold: clk/tick/pend/run=%h required 0000", {clk_out, tick, cfg_pend, running});
        end
        rst = 1'b1;
        step;
        vecs++;
        if ({clk_out, tick, running, clk_out3, running3} !== 18'h0) begin
            errs++;
            $display("FAIL reset_release: outputs=%h required 0", {clk_out, tick, running, clk_out3, running3});
        end
    endtask

    task automatic test_div2;
        logic [5:0] ec = 6'b010101;
        en = 1'b1; ch_en = 4'b0001;
        for (int k = 0; k < 6; k++) begin
            step;
            vecs++;
            if ({clk_out, tick, running} !== {3'b0, ec[k], 3'b0, ec[k], 4'b0001}) begin
                errs++;
                $display("FAIL div2 k=%0d: clk=%b tick=%b run=%b required clk=%b tick=%b run=0001",
                         k, clk_out, tick, running, {3'b0, ec[k]}, {3'b0, ec[k]});
            end
        end
        go_idle;
    endtask

    task automatic test_div5_idle;
        write(2'd0, 8'd5);
        vecs++;
        if (cfg_pend !== 4'b0 || running !== 4'b0) begin
            errs++;
            $display("FAIL div5_idle_write: pend=%b run=%b required 0000/0000", cfg_pend, running);
        end
        ch_en = 4'b0001;
        for (int k = 0; k < 10; k++) begin
            step;
            vecs++;
            if ({clk_out[0], tick[0]} !== {(k % 5) < 3, (k % 5) == 0}) begin
                errs++;
                $display("FAIL div5 k=%0d: clk,tick=%b required %b", k, {clk_out[0], tick[0]},
                         {(k % 5) < 3, (k % 5) == 0});
            end
        end
        go_idle;
    endtask

    task automatic test_change;
        logic [11:0] ec = 12'b1000_1111_0011, et = 12'b1000_0001_0001, ep = 12'b0000_0000_1100;
        write(2'd0, 8'd4);
        ch_en = 4'b0001;
        for (int k = 0; k < 12; k++) begin
            step;
            vecs++;
            if ({clk_out[0], tick[0], cfg_pend[0]} !== {ec[k], et[k], ep[k]}) begin
                errs++;
                $display("FAIL change_4to7 k=%0d: clk,tick,pend=%b required %b", k,
                         {clk_out[0], tick[0], cfg_pend[0]}, {ec[k], et[k], ep[k]});
            end
            if (k == 1) begin cfg_wr = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd7; end
            if (k == 2) cfg_wr = 1'b0;
        end
        go_idle;
    endtask

    task automatic test_boundary_write;
        logic [9:0] ec = 10'b0110110011, et = 10'b0010010001;
        write(2'd0, 8'd4);
        ch_en = 4'b0001;
        for (int k = 0; k < 10; k++) begin
            step;
            vecs++;
            if ({clk_out[0], tick[0], cfg_pend[0]} !== {ec[k], et[k], 1'b0}) begin
                errs++;
                $display("FAIL boundary_write k=%0d: clk,tick,pend=%b required %b", k,
                         {clk_out[0], tick[0], cfg_pend[0]}, {ec[k], et[k], 1'b0});
            end
            if (k == 3) begin cfg_wr = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd3; end
            if (k == 4) cfg_wr = 1'b0;
        end
        go_idle;
    endtask

    task automatic test_stop;
        logic [13:0] ec = 14'b00000111000111, er = 14'b00111111111111, et = 14'b00000001000001;
        logic [13:0] rc = 14'b11000111000111, rt = 14'b01000001000001;
        write(2'd0, 8'd6);
        ch_en = 4'b0001;
        for (int k = 0; k < 14; k++) begin
            step;
            vecs++;
            if ({clk_out[0], tick[0], running[0]} !== {ec[k], et[k], er[k]}) begin
                errs++;
                $display("FAIL stop k=%0d: clk,tick,run=%b required %b", k,
                         {clk_out[0], tick[0], running[0]}, {ec[k], et[k], er[k]});
            end
            if (k == 1) ch_en = 4'b0000;
        end
        ch_en = 4'b0001;
        for (int k = 0; k < 14; k++) begin
            step;
            vecs++;
            if ({clk_out[0], tick[0], running[0]} !== {rc[k], rt[k], 1'b1}) begin
                errs++;
                $display("FAIL stop_resume k=%0d: clk,tick,run=%b required %b", k,
                         {clk_out[0], tick[0], running[0]}, {rc[k], rt[k], 1'b1});
            end
            if (k == 1) ch_en = 4'b0000;
            if (k == 8) ch_en = 4'b0001;
        end
        go_idle;
    endtask

    task automatic test_clamp;
        logic [3:0] ec = 4'b0101;
        write(2'd0, 8'd0);
        ch_en = 4'b0001;
        for (int k = 0; k < 4; k++) begin
            step;
            vecs++;
            if ({clk_out[0], tick[0]} !== {ec[k], ec[k]}) begin
                errs++;
                $display("FAIL clamp k=%0d: clk,tick=%b required %b", k, {clk_out[0], tick[0]}, {ec[k], ec[k]});
            end
        end
        go_idle;
    endtask

    task automatic test_bad_ch;
        logic [4:0] ec = 5'b10101;
        ch_en3 = 3'b111;
        for (int k = 0; k < 5; k++) begin
            step;
            vecs++;
            if ({clk_out3, cfg_pend3} !== {{3{ec[k]}}, 3'b000}) begin
                errs++;
                $display("FAIL bad_ch k=%0d: clk3=%b pend3=%b required %b/000", k, clk_out3, cfg_pend3, {3{ec[k]}});
            end
            if (k == 0) begin cfg_wr3 = 1'b1; cfg_ch3 = 2'd3; cfg_div = 8'd5; end
            if (k == 1) cfg_wr3 = 1'b0;
        end
        ch_en3 = 3'b000;
    endtask

    task automatic test_indep_reset;
        logic [7:0] ec = 8'b10_01_11_11, et = 8'b10_00_00_11;
        write(2'd0, 8'd5);
        write(2'd1, 8'd3);
        ch_en = 4'b0011;
        for (int k = 0; k < 4; k++) begin
            step;
            vecs++;
            if ({clk_out, tick} !== {2'b0, ec[2*k+:2], 2'b0, et[2*k+:2]}) begin
                errs++;
                $display("FAIL indep k=%0d: clk=%b tick=%b required %b/%b", k, clk_out, tick,
                         {2'b0, ec[2*k+:2]}, {2'b0, et[2*k+:2]});
            end
            if (k == 3) begin cfg_wr = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd7; end
        end
        step;
        cfg_wr = 1'b0;
        vecs++;
        if (cfg_pend !== 4'b0001) begin
            errs++;
            $display("FAIL indep_pend: pend=%b required 0001", cfg_pend);
        end
        #2 rst = 1'b0;
        #1;
        vecs++;
        if ({clk_out, tick, cfg_pend, running} !== 16'h0) begin
            errs++;
            $display("FAIL async_reset: outputs=%h required 0000", {clk_out, tick, cfg_pend, running});
        end
        step;
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step;
            vecs++;
            if ({clk_out, tick, cfg_pend, running} !== {{2'b0, {2{~k[0]}}}, {2'b0, {2{~k[0]}}}, 4'b0, 4'b0011}) begin
                errs++;
                $display("FAIL post_reset_div k=%0d: clk=%b tick=%b pend=%b run=%b required clk=tick=%b pend=0000 run=0011",
                         k, clk_out, tick, cfg_pend, running, {2'b0, {2{~k[0]}}});
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset;
        test_div2;
        test_div5_idle;
        test_change;
        test_boundary_write;
        test_stop;
        test_clamp;
        test_bad_ch;
        test_indep_reset;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
